// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : 2R/2W integer register file with optional write bypass and a
//            per-register busy scoreboard (issue sets, writeback clears).
// Revision : 1.0
// ============================================================================
module regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1Addr,
  input  logic [AW-1:0]   rs2Addr,
  output logic [XLEN-1:0] rs1Data,
  output logic [XLEN-1:0] rs2Data,
  output logic            rs1Busy,
  output logic            rs2Busy,
  input  logic            issueValid,
  input  logic [AW-1:0]   issueRd,
  input  logic            w0En,
  input  logic [AW-1:0]   w0Addr,
  input  logic [XLEN-1:0] w0Data,
  input  logic            w1En,
  input  logic [AW-1:0]   w1Addr,
  input  logic [XLEN-1:0] w1Data,
  output logic [AW:0]     busyCount
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busyCount;

  logic            w_w0Act;
  logic            w_w1Act;
  logic [NREG-1:0] w_busyNext;
  logic [AW:0]     w_countNext;

  assign w_w0Act = w0En && (w0Addr != '0);
  assign w_w1Act = w1En && (w1Addr != '0);

  // Issue is applied after the writeback clears so a same-cycle race leaves busy set.
  always_comb begin
    w_busyNext = r_busy;
    if (w_w0Act) w_busyNext[w0Addr] = 1'b0;
    if (w_w1Act) w_busyNext[w1Addr] = 1'b0;
    if (issueValid && (issueRd != '0)) w_busyNext[issueRd] = 1'b1;
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_countNext = '0;
    for (int i = 0; i < NREG; i++) begin
      w_countNext = w_countNext + {{AW{1'b0}}, w_busyNext[i]};
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy      <= '0;
      r_busyCount <= '0;
    end else begin
      if (w_w0Act) r_regs[w0Addr] <= w0Data;
      if (w_w1Act) r_regs[w1Addr] <= w1Data;
      r_busy      <= w_busyNext;
      r_busyCount <= w_countNext;
    end
  end

  logic [AW-1:0]   w_rAddr [2];
  logic [XLEN-1:0] w_rData [2];
  logic            w_rBusy [2];

  assign w_rAddr[0] = rs1Addr;
  assign w_rAddr[1] = rs2Addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_hit0;
    logic w_hit1;

    assign w_hit1 = (BYPASS != 0) && w_w1Act && (w1Addr == w_rAddr[p]);
    assign w_hit0 = (BYPASS != 0) && w_w0Act && (w0Addr == w_rAddr[p]);

    assign w_rData[p] = (w_rAddr[p] == '0) ? '0     :
                        w_hit1             ? w1Data :
                        w_hit0             ? w0Data :
                                             r_regs[w_rAddr[p]];
    assign w_rBusy[p] = r_busy[w_rAddr[p]] & ~(w_hit0 | w_hit1);
  end

  assign rs1Data   = w_rData[0];
  assign rs2Data   = w_rData[1];
  assign rs1Busy   = w_rBusy[0];
  assign rs2Busy   = w_rBusy[1];
  assign busyCount = r_busyCount;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb, bypass and non-bypass builds.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1Addr, rs2Addr, issueRd, w0Addr, w1Addr;
  logic            issueValid, w0En, w1En;
  logic [XLEN-1:0] w0Data, w1Data;

  logic [XLEN-1:0] b_rs1Data, b_rs2Data, n_rs1Data, n_rs2Data;
  logic            b_rs1Busy, b_rs2Busy, n_rs1Busy, n_rs2Busy;
  logic [AW:0]     b_busyCount, n_busyCount;

  always #5 clock = ~clock;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_dut (
    .clock(clock), .reset(reset),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(b_rs1Data), .rs2Data(b_rs2Data),
    .rs1Busy(b_rs1Busy), .rs2Busy(b_rs2Busy),
    .issueValid(issueValid), .issueRd(issueRd),
    .w0En(w0En), .w0Addr(w0Addr), .w0Data(w0Data),
    .w1En(w1En), .w1Addr(w1Addr), .w1Data(w1Data),
    .busyCount(b_busyCount)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_dut_nb (
    .clock(clock), .reset(reset),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(n_rs1Data), .rs2Data(n_rs2Data),
    .rs1Busy(n_rs1Busy), .rs2Busy(n_rs2Busy),
    .issueValid(issueValid), .issueRd(issueRd),
    .w0En(w0En), .w0Addr(w0Addr), .w0Data(w0Data),
    .w1En(w1En), .w1Addr(w1Addr), .w1Data(w1Data),
    .busyCount(n_busyCount)
  );

  typedef struct {
    string           tag;
    int              sel;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t            sb_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] observe(input int sel);
    case (sel)
      0: return b_rs1Data;
      1: return b_rs2Data;
      2: return {63'd0, b_rs1Busy};
      3: return {63'd0, b_rs2Busy};
      4: return {58'd0, b_busyCount};
      5: return n_rs1Data;
      6: return n_rs2Data;
      7: return {63'd0, n_rs1Busy};
      8: return {63'd0, n_rs2Busy};
      default: return {58'd0, n_busyCount};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && w1En && w1Addr == a) return w1Data;
    if (byp && w0En && w0Addr == a) return w0Data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((w1En && w1Addr == a) || (w0En && w0Addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [XLEN-1:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return XLEN'(c);
  endfunction

  task automatic push(input string tag, input int sel, input logic [XLEN-1:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_model();
    for (int b = 0; b < 2; b++) begin
      bit byp = (b == 0);
      int o   = (b == 0) ? 0 : 5;
      push("m_rs1Data", o + 0, exp_rd(rs1Addr, byp));
      push("m_rs2Data", o + 1, exp_rd(rs2Addr, byp));
      push("m_rs1Busy", o + 2, {63'd0, exp_busy(rs1Addr, byp)});
      push("m_rs2Busy", o + 3, {63'd0, exp_busy(rs2Addr, byp)});
      push("m_busyCnt", o + 4, exp_cnt());
    end
  endtask

  task automatic drain();
    #2;
    while (sb_q.size() > 0) begin
      exp_t e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [AW-1:0] ird,
                       input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    reset = rst; issueValid = iv; issueRd = ird;
    w0En = e0; w0Addr = a0; w0Data = d0;
    w1En = e1; w1Addr = a1; w1Data = d1;
    rs1Addr = ra1; rs2Addr = ra2;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUTs.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w0En && w0Addr != 0) begin m_regs[w0Addr] = w0Data; m_busy[w0Addr] = 1'b0; end
      if (w1En && w1Addr != 0) begin m_regs[w1Addr] = w1Data; m_busy[w1Addr] = 1'b0; end
      if (issueValid && issueRd != 0) m_busy[issueRd] = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    tick();

    // Reset state and reset-with-prior-data
    drive(0, 0, 0, 1, 5, 64'hDEAD, 0, 0, 0, 5, 6);
    push("rst_rs1Data", 0, 64'hDEAD);
    push_model(); drain(); tick();
    drive(1, 1, 8, 1, 6, 64'h66, 0, 0, 0, 5, 9);
    drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    push("rst_x5", 0, 0); push("rst_x6", 1, 0);
    push("rst_busy", 2, 0); push("rst_cnt", 4, 0);
    push_model(); drain(); tick();

    // Register 0
    drive(0, 1, 0, 1, 0, 64'hFFFF, 0, 0, 0, 0, 0);
    push("x0_same", 0, 0); push("x0_busy_same", 2, 0);
    push_model(); drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("x0_later", 0, 0); push("x0_busy_later", 2, 0); push("x0_cnt", 4, 0);
    push_model(); drain(); tick();

    // Dual write collision
    drive(0, 0, 0, 1, 7, 64'h11, 1, 7, 64'h22, 0, 7);
    push("coll_byp", 1, 64'h22); push("coll_nobyp", 6, 0);
    push_model(); drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    push("coll_next", 0, 64'h22); push("coll_next_nb", 5, 64'h22);
    push_model(); drain(); tick();

    // Scoreboard
    drive(0, 1, 3, 0, 0, 0, 0, 0, 0, 3, 4);
    push_model(); drain(); tick();
    drive(0, 1, 4, 0, 0, 0, 0, 0, 0, 3, 4);
    push("sb_busy3_1", 2, 1); push("sb_cnt_1", 4, 1);
    push_model(); drain(); tick();
    drive(0, 0, 0, 1, 3, 64'h33, 0, 0, 0, 3, 4);
    push("sb_busy3_2", 7, 1); push("sb_cnt_2", 4, 2);
    push("sb_bypbusy", 2, 0); push("sb_busy4", 3, 1);
    push_model(); drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    push("sb_busy3_clr", 2, 0); push("sb_cnt_3", 4, 1); push("sb_x3", 0, 64'h33);
    push_model(); drain(); tick();

    // Issue/write race
    drive(0, 1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
    push_model(); drain(); tick();
    drive(0, 1, 9, 0, 0, 0, 1, 9, 64'h99, 9, 0);
    push("race_cnt_before", 4, 2);
    push_model(); drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    push("race_x9", 0, 64'h99); push("race_busy9", 2, 1); push("race_cnt", 4, 2);
    push_model(); drain(); tick();

    // Bypass off
    drive(0, 0, 0, 1, 2, 64'hAB, 0, 0, 0, 2, 0);
    push("nb_old", 5, 0); push("byp_new", 0, 64'hAB);
    push_model(); drain(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    push("nb_next", 5, 64'hAB);
    push_model(); drain(); tick();

    // Random traffic against the model; narrow address range forces collisions
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] mask;
      mask = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h07;
      drive(($urandom_range(0, 60) == 0),
            $urandom_range(0, 1) == 1, AW'($urandom) & mask,
            $urandom_range(0, 1) == 1, AW'($urandom) & mask, {$urandom, $urandom},
            $urandom_range(0, 1) == 1, AW'($urandom) & mask, {$urandom, $urandom},
            AW'($urandom) & mask, AW'($urandom) & mask);
      push_model(); drain(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two read ports, two write ports, optional write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 64×32, single-write file in the NPC core's decode/writeback path. Issue marks a destination busy and writeback clears it, so decode can stall on RAW hazards without a separate scoreboard block.

## Interface
Parameters:
- XLEN, 64, data width in bits (≥ 8).
- NREG, 32, number of architectural registers (power of two, ≥ 2); AW = log2(NREG).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored state.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rs1Addr  in  AW  read port 1 address.
- rs2Addr  in  AW  read port 2 address.
- rs1Data  out  XLEN  read port 1 data.
- rs2Data  out  XLEN  read port 2 data.
- rs1Busy  out  1  register rs1Addr has a pending write.
- rs2Busy  out  1  register rs2Addr has a pending write.
- issueValid  in  1  an instruction writing issueRd issues this cycle.
- issueRd  in  AW  destination register of the issuing instruction.
- w0En  in  1  write port 0 enable.
- w0Addr  in  AW  write port 0 address.
- w0Data  in  XLEN  write port 0 data.
- w1En  in  1  write port 1 enable (higher priority than port 0).
- w1Addr  in  AW  write port 1 address.
- w1Data  in  XLEN  write port 1 data.
- busyCount  out  AW+1  number of registers currently busy.

## Operation
- State: regs[NREG] of XLEN bits, plus busy[NREG] of 1 bit each. Register 0 is hardwired: it reads 0, is never busy and ignores all writes and issues.
- Reset, when high at a posedge: all regs = 0, all busy = 0, busyCount = 0. Reset overrides any write or issue in the same cycle. Asserting reset mid-operation discards pending busy marks.
- Write, at posedge with wNEn and wNAddr ≠ 0: regs[wNAddr] ← wNData and busy[wNAddr] ← 0.
  - If both ports target the same address, port 1's data is stored and port 0 is dropped.
- Issue, at posedge with issueValid and issueRd ≠ 0: busy[issueRd] ← 1.
  - If a write hits the same register in the same cycle, the data is written but busy ends up 1 (issue wins).
- Read is combinational:
  - rsNData = 0 if rsNAddr = 0.
  - With BYPASS=1:
    - If w1En and w1Addr = rsNAddr ≠ 0, the port returns w1Data.
    - Else if w0En and w0Addr = rsNAddr ≠ 0, it returns w0Data.
    - Else it returns regs[rsNAddr].
  - With BYPASS=0: always regs[rsNAddr].
- rsNBusy = busy[rsNAddr]. With BYPASS=1 it is forced to 0 when either write port hits rsNAddr this cycle. A same-cycle issue never affects rsNBusy.
- busyCount is the registered popcount of busy, updated together with busy. Its range is 0..NREG-1.

## Timing
- Write latency is 1 cycle to stored state. With BYPASS=1, read-after-write has 0-cycle visibility.
- Issue→busy takes 1 cycle. Writeback→busy clear takes 1 cycle, or 0 cycles on rsNBusy when BYPASS=1.
- Read paths are purely combinational from addresses, write ports and state. There are no read handshakes.
- Every output is 0 in the cycle after reset, for any address.

## Test plan
- Reset with prior data:
  - Stimulus: write x5 = 0xDEAD, then reset for 1 cycle, then read rs1Addr=5.
  - Required: rs1Data = 0, rs1Busy = 0, busyCount = 0.
  - Also: a write to x6 issued in the same cycle as reset leaves x6 = 0.
- Register 0:
  - Stimulus: w0En, w0Addr=0, w0Data=0xFFFF, plus issueValid with issueRd=0.
  - Required: rs1Addr=0 reads 0 and rs1Busy=0 in all later cycles; busyCount unchanged.
- Dual write collision:
  - Stimulus: w0 and w1 both target x7, w0Data=0x11, w1Data=0x22.
  - Required, next cycle: x7 reads 0x22.
  - Required, BYPASS=1 same cycle: rs2Addr=7 reads 0x22.
- Scoreboard:
  - Stimulus: issue x3, then x4 on consecutive cycles.
  - Required: rs1Busy(3) = 1 and busyCount = 2. After a w0 write to x3 (0x33), busy(3) = 0, busyCount = 1 and x3 reads 0x33.
- Issue/write race:
  - Stimulus: busy(9)=1; in the same cycle, w1 writes x9 = 0x99 and issueRd = 9.
  - Required next cycle: x9 = 0x99, busy(9) = 1, busyCount unchanged.
- Bypass off:
  - Stimulus: BYPASS=0 build, write x2 = 0xAB with rs1Addr=2 in the same cycle.
  - Required: rs1Data shows the old value in that cycle and 0xAB in the next.
